// File: rtl/rv32i_types.sv
// Shared types and constants for the RV32I writeback path.
package rv32i_types;

    // Writeback source select carried down the pipe from decode.
    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_LOAD = 3'd1,
        WB_PC4  = 3'd2,
        WB_IMM  = 3'd3,
        WB_BR   = 3'd4
    } wb_sel_t;

    // Load width/sign encodings (funct3). Any other value is handled as a word load.
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    // Writeback stage occupancy.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_WAIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Selects and extends the addressed byte/halfword of a raw load word.
module load_align
    import rv32i_types::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by sign/zero extension by funct3.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // Halfword lane comes from addr[1]; misaligned addr[0] is ignored.
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, load-response wait and regfile write port.
module wb_stage
    import rv32i_types::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGS_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_valid,
    input  logic                 mem_regwrite,
    input  logic [REGS_LOG2-1:0] mem_rd,
    input  logic [2:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_alu_out,
    input  logic [XLEN-1:0]      mem_pc,
    input  logic [XLEN-1:0]      mem_imm,
    input  logic                 mem_br_en,
    input  logic                 stall,
    input  logic                 dmem_resp,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 wb_ready,
    output logic                 rf_load,
    output logic [REGS_LOG2-1:0] rf_dest,
    output logic [XLEN-1:0]      rf_in,
    output logic                 fwd_valid,
    output logic [REGS_LOG2-1:0] fwd_rd
);

    wb_state_t             state_q, state_d;
    logic [REGS_LOG2-1:0]  rd_q, rd_d;
    logic                  regwrite_q, regwrite_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_q, addr_d;

    logic                  accept;
    logic [XLEN-1:0]       direct_result;
    logic [XLEN-1:0]       load_data;

    assign wb_ready = (state_q != S_WAIT);
    assign accept   = mem_valid && !stall && wb_ready;

    // Load metadata is latched at accept, so alignment works from registered state.
    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .funct3 (funct3_q),
        .addr   (addr_q),
        .rdata  (dmem_rdata),
        .data   (load_data)
    );

    // Result for non-load sources, formed at capture time.
    always_comb begin
        case (mem_wb_sel)
            WB_PC4:  direct_result = mem_pc + XLEN'(4);
            WB_IMM:  direct_result = mem_imm;
            WB_BR:   direct_result = {{(XLEN-1){1'b0}}, mem_br_en};
            default: direct_result = mem_alu_out;
        endcase
    end

    // Next-state and pipeline register update.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        result_d   = result_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;

        case (state_q)
            S_IDLE, S_COMMIT: begin
                if (accept) begin
                    rd_d       = mem_rd;
                    regwrite_d = mem_regwrite;
                    funct3_d   = mem_funct3;
                    addr_d     = mem_alu_out[1:0];
                    if (mem_wb_sel == WB_LOAD) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d  = S_COMMIT;
                        result_d = direct_result;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // No timeout: the stage holds until memory answers.
                if (dmem_resp) begin
                    result_d = load_data;
                    state_d  = S_COMMIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            result_q   <= '0;
            funct3_q   <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            result_q   <= result_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
        end
    end

    // Write port is purely registered; x0 writes are suppressed here.
    assign rf_load   = (state_q == S_COMMIT) && regwrite_q && (rd_q != '0);
    assign rf_dest   = rd_q;
    assign rf_in     = result_q;
    assign fwd_valid = rf_load;
    assign fwd_rd    = rf_dest;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table, directed corner cases, random vs model.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_pc;
    logic [31:0] mem_imm;
    logic        mem_br_en;
    logic        stall;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        wb_ready;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;

    int checks = 0;
    int errors = 0;

    wb_stage #(
        .XLEN      (32),
        .REGS_LOG2 (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_wb_sel   (mem_wb_sel),
        .mem_funct3   (mem_funct3),
        .mem_alu_out  (mem_alu_out),
        .mem_pc       (mem_pc),
        .mem_imm      (mem_imm),
        .mem_br_en    (mem_br_en),
        .stall        (stall),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .wb_ready     (wb_ready),
        .rf_load      (rf_load),
        .rf_dest      (rf_dest),
        .rf_in        (rf_in),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        br;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid    = 1'b0;
        mem_regwrite = 1'b0;
        mem_rd       = '0;
        mem_wb_sel   = 3'd0;
        mem_funct3   = 3'd0;
        mem_alu_out  = '0;
        mem_pc       = '0;
        mem_imm      = '0;
        mem_br_en    = 1'b0;
        stall        = 1'b0;
        dmem_resp    = 1'b0;
        dmem_rdata   = '0;
    endtask

    task automatic drive_op(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [2:0] f3);
        mem_valid    = 1'b1;
        mem_regwrite = 1'b1;
        mem_rd       = rd;
        mem_wb_sel   = sel;
        mem_funct3   = f3;
        mem_alu_out  = alu;
    endtask

    // Reference: extended load value computed arithmetically from the word.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * int'(a))) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] sel, input logic [31:0] alu,
                                               input logic [31:0] pc, input logic [31:0] imm,
                                               input logic br);
        case (sel)
            3'd2:    return pc + 32'd4;
            3'd3:    return imm;
            3'd4:    return br ? 32'd1 : 32'd0;
            default: return alu;
        endcase
    endfunction

    task automatic apply_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        mem_valid    = 1'b1;
        mem_regwrite = 1'b1;
        mem_rd       = v.rd;
        mem_wb_sel   = v.sel;
        mem_funct3   = v.f3;
        mem_alu_out  = v.alu;
        mem_pc       = v.pc;
        mem_imm      = v.imm;
        mem_br_en    = v.br;
        tick();
        mem_valid = 1'b0;
        if (v.sel == 3'd1) begin
            chk({tag, "_wait_ready0"}, 32'(wb_ready), 32'd0);
            chk({tag, "_wait_noload0"}, 32'(rf_load), 32'd0);
            tick();
            chk({tag, "_wait_ready1"}, 32'(wb_ready), 32'd0);
            dmem_resp  = 1'b1;
            dmem_rdata = v.rdata;
            tick();
            dmem_resp  = 1'b0;
            dmem_rdata = 32'h0;
        end
        chk({tag, "_rf_load"}, 32'(rf_load), 32'd1);
        chk({tag, "_rf_dest"}, 32'(rf_dest), 32'(v.rd));
        chk({tag, "_rf_in"}, rf_in, v.exp);
        chk({tag, "_fwd_rd"}, 32'(fwd_rd), 32'(v.rd));
        tick();
        chk({tag, "_after"}, 32'(rf_load), 32'd0);
    endtask

    initial begin
        // sel f3 alu pc imm br rdata rd exp
        vecs[0]  = '{3'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 32'h0, 5'd5, 32'h0000_1234};
        vecs[1]  = '{3'd1, 3'd0, 32'h1000_0002, 32'h0, 32'h0, 1'b0, 32'h0080_0000, 5'd3,
                     32'hFFFF_FF80};
        vecs[2]  = '{3'd1, 3'd5, 32'h1000_0002, 32'h0, 32'h0, 1'b0, 32'hBEEF_0000, 5'd4,
                     32'h0000_BEEF};
        vecs[3]  = '{3'd1, 3'd2, 32'h1000_0003, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 5'd6,
                     32'hDEAD_BEEF};
        vecs[4]  = '{3'd2, 3'd0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 5'd7, 32'h0000_0000};
        vecs[5]  = '{3'd3, 3'd0, 32'h0, 32'h0, 32'hABCD_E000, 1'b0, 32'h0, 5'd8, 32'hABCD_E000};
        vecs[6]  = '{3'd4, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 5'd9, 32'h0000_0001};
        vecs[7]  = '{3'd1, 3'd1, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 32'h1234_8001, 5'd10,
                     32'hFFFF_8001};
        vecs[8]  = '{3'd1, 3'd4, 32'h0000_0003, 32'h0, 32'h0, 1'b0, 32'h8000_0000, 5'd11,
                     32'h0000_0080};
        vecs[9]  = '{3'd1, 3'd0, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 32'h0000_7F00, 5'd12,
                     32'h0000_007F};
        vecs[10] = '{3'd1, 3'd3, 32'h0000_0002, 32'h0, 32'h0, 1'b0, 32'h0102_0304, 5'd13,
                     32'h0102_0304};
        vecs[11] = '{3'd1, 3'd6, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 5'd31,
                     32'hCAFE_F00D};

        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset_wb_ready", 32'(wb_ready), 32'd1);
        chk("reset_rf_load", 32'(rf_load), 32'd0);
        chk("reset_rf_dest", 32'(rf_dest), 32'd0);
        chk("reset_rf_in", rf_in, 32'd0);
        chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Back-to-back ALU writes, no bubble.
        drive_op(3'd0, 5'd1, 32'h11, 3'd0);
        tick();
        drive_op(3'd0, 5'd2, 32'h22, 3'd0);
        chk("b2b_first_load", 32'(rf_load), 32'd1);
        chk("b2b_first_dest", 32'(rf_dest), 32'd1);
        chk("b2b_first_in", rf_in, 32'h11);
        tick();
        mem_valid = 1'b0;
        chk("b2b_second_load", 32'(rf_load), 32'd1);
        chk("b2b_second_dest", 32'(rf_dest), 32'd2);
        chk("b2b_second_in", rf_in, 32'h22);
        tick();
        chk("b2b_drain", 32'(rf_load), 32'd0);

        // Writes to x0 and non-writing instructions never assert rf_load.
        drive_op(3'd0, 5'd0, 32'h55, 3'd0);
        tick();
        mem_valid = 1'b0;
        chk("rd0_noload", 32'(rf_load), 32'd0);
        chk("rd0_nofwd", 32'(fwd_valid), 32'd0);
        drive_op(3'd0, 5'd7, 32'h66, 3'd0);
        mem_regwrite = 1'b0;
        tick();
        mem_valid = 1'b0;
        chk("store_noload", 32'(rf_load), 32'd0);
        chk("store_ready", 32'(wb_ready), 32'd1);
        tick();

        // Stall blocks capture.
        drive_op(3'd0, 5'd9, 32'h99, 3'd0);
        stall = 1'b1;
        tick();
        chk("stall_nocap0", 32'(rf_load), 32'd0);
        tick();
        chk("stall_nocap1", 32'(rf_load), 32'd0);
        idle_inputs();

        // Stall while committing: write still happens, then idle.
        drive_op(3'd0, 5'd4, 32'h44, 3'd0);
        tick();
        drive_op(3'd0, 5'd6, 32'h77, 3'd0);
        stall = 1'b1;
        chk("stall_commit_load", 32'(rf_load), 32'd1);
        chk("stall_commit_dest", 32'(rf_dest), 32'd4);
        tick();
        chk("stall_commit_idle", 32'(rf_load), 32'd0);
        idle_inputs();

        // Stall while waiting: load still completes.
        drive_op(3'd1, 5'd8, 32'h0, 3'd2);
        tick();
        idle_inputs();
        stall      = 1'b1;
        mem_valid  = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h1234_5678;
        tick();
        idle_inputs();
        chk("stall_wait_load", 32'(rf_load), 32'd1);
        chk("stall_wait_in", rf_in, 32'h1234_5678);
        tick();

        // dmem_resp while committing is ignored.
        drive_op(3'd0, 5'd11, 32'hB0, 3'd0);
        tick();
        mem_valid = 1'b0;
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        chk("resp_commit_ignored", 32'(rf_load), 32'd0);
        chk("resp_commit_ready", 32'(wb_ready), 32'd1);

        // Reset during wait abandons the load.
        drive_op(3'd1, 5'd10, 32'h0, 3'd2);
        tick();
        mem_valid = 1'b0;
        chk("rst_wait_ready0", 32'(wb_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_dest", 32'(rf_dest), 32'd0);
        #2;
        rst_n      = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_resp = 1'b0;
        chk("rst_wait_noload", 32'(rf_load), 32'd0);
        chk("rst_wait_ready", 32'(wb_ready), 32'd1);
        tick();
        chk("rst_wait_still", 32'(rf_load), 32'd0);

        // Random stimulus against a transaction-level model.
        begin
            bit          m_wait = 1'b0;
            logic [4:0]  m_rd = '0;
            logic        m_rw = 1'b0;
            logic [2:0]  m_f3 = '0;
            logic [1:0]  m_a = '0;
            bit          commit;
            logic [4:0]  c_rd;
            logic        c_rw;
            logic [31:0] c_data;
            bit          exp_load;
            for (int n = 0; n < 400; n++) begin
                mem_valid    = ($urandom_range(0, 3) != 0);
                mem_regwrite = ($urandom_range(0, 4) != 0);
                mem_rd       = 5'($urandom_range(0, 31));
                mem_wb_sel   = 3'($urandom_range(0, 4));
                mem_funct3   = 3'($urandom_range(0, 7));
                mem_alu_out  = $urandom;
                mem_pc       = $urandom;
                mem_imm      = $urandom;
                mem_br_en    = 1'($urandom_range(0, 1));
                stall        = ($urandom_range(0, 3) == 0);
                dmem_resp    = ($urandom_range(0, 2) == 0);
                dmem_rdata   = $urandom;

                commit = 1'b0;
                c_rd   = '0;
                c_rw   = 1'b0;
                c_data = '0;
                if (m_wait) begin
                    if (dmem_resp) begin
                        commit = 1'b1;
                        c_rd   = m_rd;
                        c_rw   = m_rw;
                        c_data = ref_load(m_f3, m_a, dmem_rdata);
                        m_wait = 1'b0;
                    end
                end else if (mem_valid && !stall) begin
                    if (mem_wb_sel == 3'd1) begin
                        m_wait = 1'b1;
                        m_rd   = mem_rd;
                        m_rw   = mem_regwrite;
                        m_f3   = mem_funct3;
                        m_a    = mem_alu_out[1:0];
                    end else begin
                        commit = 1'b1;
                        c_rd   = mem_rd;
                        c_rw   = mem_regwrite;
                        c_data = ref_result(mem_wb_sel, mem_alu_out, mem_pc, mem_imm, mem_br_en);
                    end
                end
                tick();
                exp_load = commit && c_rw && (c_rd != 5'd0);
                chk("rand_ready", 32'(wb_ready), 32'(!m_wait));
                chk("rand_rf_load", 32'(rf_load), 32'(exp_load));
                chk("rand_fwd_valid", 32'(fwd_valid), 32'(exp_load));
                if (exp_load) begin
                    chk("rand_rf_dest", 32'(rf_dest), 32'(c_rd));
                    chk("rand_rf_in", rf_in, c_data);
                    chk("rand_fwd_rd", 32'(fwd_rd), 32'(c_rd));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the pipelined RV32I core. Sits directly upstream of the register file. Holds the MEM/WB pipeline register, waits for data-memory load responses, and sign/zero-extends the loaded bytes. Drives the regfile write port (load/in/dest) and a forwarding tap for the hazard logic.

Parameters:
XLEN, 32, datapath width
REGS_LOG2, 5, register index width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage presents an instruction
mem_regwrite  in  1  instruction writes rd
mem_rd  in  5  destination register
mem_wb_sel  in  3  writeback source (wb_sel_t)
mem_funct3  in  3  load width/sign
mem_alu_out  in  32  ALU result / load address
mem_pc  in  32  instruction PC
mem_imm  in  32  U-immediate
mem_br_en  in  1  compare result
stall  in  1  hazard unit freezes capture
dmem_resp  in  1  load data valid (single-cycle pulse)
dmem_rdata  in  32  raw word from data memory
wb_ready  out  1  stage accepts a new instruction this cycle
rf_load  out  1  regfile write enable
rf_dest  out  5  regfile write index
rf_in  out  32  regfile write data
fwd_valid  out  1  rf_in is a valid forwarding value
fwd_rd  out  5  forwarding index (equals rf_dest)

Behaviour:
- Async reset (rst_n=0): state S_IDLE, pipeline register cleared, rf_load=0, rf_dest=0, rf_in=0, fwd_valid=0, wb_ready=1.
- FSM states: S_IDLE (empty), S_COMMIT (result held, written this cycle), S_WAIT (load outstanding).
- Accept condition: mem_valid && !stall && wb_ready. wb_ready=1 in S_IDLE and S_COMMIT, 0 in S_WAIT.
- Accept with wb_sel != LOAD -> S_COMMIT next cycle. Result computed at capture: ALU -> alu_out; PC4 -> pc+4 (mod 2^32); IMM -> imm; BR -> {31'b0, br_en}.
- Accept with wb_sel == LOAD -> S_WAIT. In S_WAIT, dmem_resp=1 captures the aligned result and moves to S_COMMIT on the next edge. No timeout.
- S_COMMIT without a new accept -> S_IDLE. S_COMMIT with an accept loads the new instruction back to back, with no bubble.
- In S_COMMIT, rf_load = regwrite && (rd != 0). rf_dest = rd and rf_in = result, all driven from registers with no combinational input path. Outside S_COMMIT, rf_load=0.
- rf_load is high for exactly one cycle per retired writing instruction.
- fwd_valid = rf_load; fwd_rd = rf_dest.
- Latency: non-load captured at edge N writes during cycle N+1. Load writes in the cycle after the one where dmem_resp=1.
- Load alignment uses a = alu_out[1:0]:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: halfword a[1], extended; a[0] ignored.
  - LW: full word; a ignored.
  - funct3 values 3, 6, 7 are treated as LW.
- dmem_resp is ignored in S_IDLE and S_COMMIT.
- stall=1 blocks capture only. A held S_COMMIT still writes and then goes to S_IDLE; S_WAIT still completes.
- An accepted instruction with regwrite=0 (store/branch) passes through S_COMMIT with rf_load=0. Stores use wb_sel != LOAD and never enter S_WAIT.
- Reset during S_WAIT abandons the load. A later dmem_resp in S_IDLE is ignored.

Decomposition:
- Package rv32i_types:
  - wb_sel_t enum {WB_ALU, WB_LOAD, WB_PC4, WB_IMM, WB_BR}
  - load funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5)
  - wb_state_t
- Sub-module load_align: combinational (funct3, addr[1:0], rdata) -> 32-bit extended data.

Test Plan:
- Reset, then ALU op rd=5, alu_out=0x1234 accepted at edge 1 -> cycle 2: rf_load=1, rf_dest=5, rf_in=0x00001234; cycle 3: rf_load=0.
- LB with rd=3, alu_out=0x...02, funct3=0; dmem_resp two cycles later with rdata=0x00800000 -> wb_ready=0 while waiting; the cycle after the response: rf_in=0xFFFFFF80, rf_dest=3.
- LHU with addr[1]=1, rdata=0xBEEF0000 -> rf_in=0x0000BEEF; LW rdata=0xDEADBEEF -> rf_in=0xDEADBEEF.
- Back-to-back ALU ops to rd=1, rd=2 on consecutive cycles -> rf_load high two consecutive cycles with dests 1 and 2, no bubble; rd=0 op -> rf_load=0.
- PC4 with pc=0xFFFFFFFC -> rf_in=0x00000000; IMM 0xABCDE000 -> 0xABCDE000; BR br_en=1 -> 0x00000001.
- rst_n pulsed low during S_WAIT, then dmem_resp=1 -> no rf_load, state S_IDLE, wb_ready=1. Also stall=1 with mem_valid=1 -> no capture.
